// File: rtl/button_event_pkg.sv
// Shared types, counter sizing and 27 MHz timing defaults for the push-button front end.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESSED,
    ST_HELD
  } btn_state_t;

  localparam int DEF_TICK_DIV       = 27000;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_DEBOUNCE_TICKS = 10;
  localparam int DEF_LONG_TICKS     = 500;
  localparam int DEF_REPEAT_TICKS   = 100;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: input synchroniser, tick-based debounce and the event FSM.
// state       | meaning
// ST_RELEASED | debounced level is released, waiting for an accepted press
// ST_PRESSED  | pressed, hold counter running toward the long-press threshold
// ST_HELD     | long press fired, auto-repeat timer runs while repeat_en is set
module button_event_channel
  import button_event_pkg::*;
#(
  parameter logic ACTIVE_LEVEL   = 1'b1,
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int   LONG_TICKS     = DEF_LONG_TICKS,
  parameter int   REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic repeat_en,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_click,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_TICKS);
  localparam int HOLD_W = cnt_width(LONG_TICKS);
  localparam int REP_W  = cnt_width(REPEAT_TICKS);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_i;
  logic                   stable;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   flip;
  logic                   accept_press;
  logic                   accept_release;
  btn_state_t             state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [REP_W-1:0]       rep_cnt;

  assign sync_i         = sync_q[SYNC_STAGES-1];
  assign flip           = tick && (sync_i != stable) && (deb_cnt == DEB_LAST);
  assign accept_press   = flip && !stable;
  assign accept_release = flip && stable;
  assign btn_level      = stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button ~^ ACTIVE_LEVEL};
    end
  end

  // Any cycle back at the stable level wipes progress, so sub-tick glitches never add up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_i == stable) begin
      deb_cnt <= '0;
    end else if (flip) begin
      stable  <= ~stable;
      deb_cnt <= '0;
    end else if (tick) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RELEASED;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_click   <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_click   <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (accept_press) begin
            state     <= ST_PRESSED;
            btn_press <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        ST_PRESSED: begin
          // Release is checked first so it wins a tie with the long-press threshold.
          if (accept_release) begin
            state       <= ST_RELEASED;
            btn_release <= 1'b1;
            btn_click   <= 1'b1;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_HELD;
              btn_long <= 1'b1;
              hold_cnt <= HOLD_SAT;
              rep_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (accept_release) begin
            state       <= ST_RELEASED;
            btn_release <= 1'b1;
          end else if (!repeat_en) begin
            rep_cnt <= '0;
          end else if (tick) begin
            if (rep_cnt == REP_LAST) begin
              btn_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel push-button front end: one shared tick prescaler feeding
// an independent debounce/event channel per button.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int   CHANNELS       = 2,
  parameter logic ACTIVE_LEVEL   = 1'b1,
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int   TICK_DIV       = DEF_TICK_DIV,
  parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int   LONG_TICKS     = DEF_LONG_TICKS,
  parameter int   REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] repeat_en,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_click,
  output logic [CHANNELS-1:0] btn_long,
  output logic [CHANNELS-1:0] btn_repeat
);

  localparam int                TICK_W    = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // With TICK_DIV of 1 the counter sits at 0 and tick stays high.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_event_channel #(
      .ACTIVE_LEVEL  (ACTIVE_LEVEL),
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .repeat_en  (repeat_en[i]),
      .button     (button[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_click  (btn_click[i]),
      .btn_long   (btn_long[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with short timing (4 clk ticks,
// debounce 3, long 10, repeat 4): vector table plus multi-cycle corner sequences.
module tb_button_event_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] repeat_en;
  logic [1:0] button;
  logic [1:0] btn_level, btn_press, btn_release, btn_click, btn_long, btn_repeat;

  int checks = 0;
  int errors = 0;

  // Event pulse counts per kind (0 press,1 release,2 click,3 long,4 repeat) and channel.
  int cnt [5][2];
  int snap[5][2];

  typedef struct {
    string      name;
    logic [1:0] btn;
    logic [1:0] rep;
    int         clks;
    int         e_press;
    int         e_rel;
    int         e_click;
    int         e_long;
    int         e_rep;
    int         e_ch1;
    logic [1:0] e_level;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  button_event_detector #(
    .CHANNELS      (2),
    .ACTIVE_LEVEL  (1'b1),
    .SYNC_STAGES   (2),
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .LONG_TICKS    (10),
    .REPEAT_TICKS  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .repeat_en  (repeat_en),
    .button     (button),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_click  (btn_click),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  function automatic logic [1:0] ev_bits(input int k);
    case (k)
      0:       return btn_press;
      1:       return btn_release;
      2:       return btn_click;
      3:       return btn_long;
      default: return btn_repeat;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    logic [1:0] b;
    if (reset_n) begin
      for (int k = 0; k < 5; k++) begin
        b = ev_bits(k);
        for (int c = 0; c < 2; c++) cnt[k][c] += int'(b[c]);
      end
    end
  end

  function automatic vec_t mk(input string nm, input logic [1:0] b, input logic [1:0] r,
                              input int c, input int p, input int rl, input int ck,
                              input int lg, input int rp, input int c1, input logic [1:0] lv);
    vec_t v;
    v.name = nm; v.btn = b; v.rep = r; v.clks = c;
    v.e_press = p; v.e_rel = rl; v.e_click = ck; v.e_long = lg; v.e_rep = rp;
    v.e_ch1 = c1; v.e_level = lv;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic take_snap();
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 2; c++) snap[k][c] = cnt[k][c];
  endtask

  function automatic int delta(input int k, input int c);
    return cnt[k][c] - snap[k][c];
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts negedges until the selected pulse is seen, up to budget.
  task automatic wait_pulse(input int k, input int c, input int budget,
                            output int n, output int found);
    logic [1:0] b;
    n = 0;
    found = 0;
    while (found == 0 && n < budget) begin
      @(negedge clk);
      n++;
      b = ev_bits(k);
      if (b[c]) found = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n, found, ch1_sum;

    vecs[0] = mk("idle",       2'b00, 2'b00, 10, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[1] = mk("press",      2'b01, 2'b00, 20, 1, 0, 0, 0, 0, 0, 2'b01);
    vecs[2] = mk("click",      2'b00, 2'b00, 20, 0, 1, 1, 0, 0, 0, 2'b00);
    vecs[3] = mk("hold_rep",   2'b01, 2'b01, 80, 1, 0, 0, 1, 1, 0, 2'b01);
    vecs[4] = mk("rel_rep",    2'b00, 2'b01, 30, 0, 1, 0, 0, 1, 0, 2'b00);
    vecs[5] = mk("hold_norep", 2'b01, 2'b00, 80, 1, 0, 0, 1, 0, 0, 2'b01);
    vecs[6] = mk("rel_norep",  2'b00, 2'b00, 30, 0, 1, 0, 0, 0, 0, 2'b00);
    vecs[7] = mk("both_press", 2'b11, 2'b00, 20, 1, 0, 0, 0, 0, 1, 2'b11);
    vecs[8] = mk("both_rel",   2'b00, 2'b00, 20, 0, 1, 1, 0, 0, 2, 2'b00);

    reset_n   = 1'b0;
    button    = 2'b00;
    repeat_en = 2'b00;
    repeat (3) @(negedge clk);
    check("reset pulses", int'({btn_press, btn_release, btn_click, btn_long, btn_repeat}), 0);
    check("reset level", int'(btn_level), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      button    = vecs[i].btn;
      repeat_en = vecs[i].rep;
      take_snap();
      wait_clks(vecs[i].clks);
      check({vecs[i].name, " press0"},   delta(0, 0), vecs[i].e_press);
      check({vecs[i].name, " release0"}, delta(1, 0), vecs[i].e_rel);
      check({vecs[i].name, " click0"},   delta(2, 0), vecs[i].e_click);
      check({vecs[i].name, " long0"},    delta(3, 0), vecs[i].e_long);
      check({vecs[i].name, " repeat0"},  delta(4, 0), vecs[i].e_rep);
      ch1_sum = 0;
      for (int k = 0; k < 5; k++) ch1_sum += delta(k, 1);
      check({vecs[i].name, " ch1 events"}, ch1_sum, vecs[i].e_ch1);
      check({vecs[i].name, " level"}, int'(btn_level), int'(vecs[i].e_level));
    end

    // Press latency from the input edge.
    button = 2'b01;
    wait_pulse(0, 0, 30, n, found);
    check("latency press seen", found, 1);
    check_range("latency press clocks", n, 11, 15);
    check("latency level with press", int'(btn_level), 1);
    @(posedge clk);
    #1;
    button = 2'b00;
    wait_clks(25);

    // Chatter shorter than the debounce window must be ignored.
    take_snap();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) button[0] = ~button[0];
      wait_clks(1);
    end
    check("chatter press count", delta(0, 0), 0);
    check("chatter level", int'(btn_level), 0);
    button[0] = 1'b1;
    wait_pulse(0, 0, 20, n, found);
    check("chatter settle press seen", found, 1);
    wait_clks(10);
    check("chatter single press", delta(0, 0), 1);
    button = 2'b00;
    wait_clks(25);

    // Long-press and auto-repeat spacing.
    repeat_en = 2'b01;
    button    = 2'b01;
    wait_pulse(0, 0, 30, n, found);
    check("long seq press seen", found, 1);
    wait_pulse(3, 0, 60, n, found);
    check("long seq long seen", found, 1);
    check("long after press clocks", n, 40);
    wait_pulse(4, 0, 30, n, found);
    check("first repeat clocks", n, 16);
    wait_pulse(4, 0, 30, n, found);
    check("second repeat clocks", n, 16);
    @(posedge clk);
    #1;
    take_snap();
    button = 2'b00;
    wait_clks(25);
    check("held release count", delta(1, 0), 1);
    check("held release no click", delta(2, 0), 0);
    repeat_en = 2'b00;

    // Simultaneous presses pulse in the same clock.
    button = 2'b11;
    wait_pulse(0, 0, 30, n, found);
    check("simul press seen", found, 1);
    check("simul press bits", int'(btn_press), 3);
    @(posedge clk);
    #1;
    button = 2'b00;
    wait_clks(25);

    // Reset in the middle of a held press.
    repeat_en = 2'b01;
    button    = 2'b01;
    wait_pulse(3, 0, 80, n, found);
    check("reset seq long seen", found, 1);
    take_snap();
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid reset pulses", int'({btn_press, btn_release, btn_click, btn_long, btn_repeat}), 0);
    check("mid reset level", int'(btn_level), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_pulse(0, 0, 20, n, found);
    check("post reset press seen", found, 1);
    check_range("post reset press clocks", n, 1, 15);
    check("post reset no release", delta(1, 0), 0);
    @(posedge clk);
    #1;
    button    = 2'b00;
    repeat_en = 2'b00;
    wait_clks(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
